// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the 5-stage MIPS pipeline hazard controller:
//   FSM state encoding, PC source select codes and a helper that chooses
//   the redirect target.
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] PC_SEL_PC4    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
   localparam logic [1:0] PC_SEL_JR     = 2'd3;

   // jr beats j/jal, which beats a taken branch.
   function automatic logic [1:0] redirect_sel(input logic jmp, input logic topc);
      if (topc)
         return PC_SEL_JR;
      else if (jmp)
         return PC_SEL_JUMP;
      else
         return PC_SEL_BRANCH;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the performance counts. Holds at
//   all-ones instead of wrapping.
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous active-low reset (clears the count)
//     i_inc    add one this cycle
//     o_count  current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_inc,
   output logic [CNT_WIDTH-1:0] o_count
);

   logic [CNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_count <= '0;
      else if (i_inc && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//   Drives the enables and flushes of the IF/ID, ID/EX and EX/MEM pipeline
//   registers. Stalls the front end on load-use hazards (bubble into ID/EX)
//   and flushes wrong-path stages when a branch/jump/jr resolves in MEM.
//   All control outputs respond in the same cycle as their inputs.
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     ifid_rs_i/rt_i      source fields of the instruction in ID
//     idex_mem_read_i     EX holds a load;  idex_rt_i its destination
//     exmem_branch_i/zero_i/jmp_i/topc_i   redirect sources in MEM
//     pc_enable_o, ifid_enable_o           register load enables
//     ifid/idex/exmem_flush_o              stage flushes
//     pc_sel_o            0 PC+4, 1 branch, 2 jump, 3 jr register
//     stall_count_o       stall cycles seen (saturating)
//     flush_count_o       redirect events seen (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           ifid_rs_i,
   input  logic [4:0]           ifid_rt_i,
   input  logic                 idex_mem_read_i,
   input  logic [4:0]           idex_rt_i,
   input  logic                 exmem_branch_i,
   input  logic                 exmem_zero_i,
   input  logic                 exmem_jmp_i,
   input  logic                 exmem_topc_i,
   output logic                 pc_enable_o,
   output logic                 ifid_enable_o,
   output logic                 ifid_flush_o,
   output logic                 idex_flush_o,
   output logic                 exmem_flush_o,
   output logic [1:0]           pc_sel_o,
   output logic [CNT_WIDTH-1:0] stall_count_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   localparam int MAX_CYC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
   localparam int REM_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
   localparam logic [REM_W-1:0] STALL_REM = REM_W'(STALL_CYCLES - 1);
   localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYCLES - 1);
   localparam logic [REM_W-1:0] REM_LAST  = REM_W'(1);

   state_t           r_state, w_next_state;
   logic [REM_W-1:0] r_rem, w_next_rem;
   logic             w_redirect, w_load_use;
   logic             w_stall_inc, w_flush_inc;

   assign w_redirect = (exmem_branch_i & exmem_zero_i) | exmem_jmp_i | exmem_topc_i;
   assign w_load_use = idex_mem_read_i & (idex_rt_i != 5'd0) &
                       ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_rem   <= '0;
      end else begin
         r_state <= w_next_state;
         r_rem   <= w_next_rem;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_rem    = r_rem;
      pc_enable_o   = 1'b1;
      ifid_enable_o = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      pc_sel_o      = PC_SEL_PC4;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;

      // A redirect wins in every state: it aborts a stall and restarts a flush.
      if (w_redirect) begin
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
         pc_sel_o      = redirect_sel(exmem_jmp_i, exmem_topc_i);
         w_flush_inc   = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_next_state = FLUSH;
            w_next_rem   = FLUSH_REM;
         end else begin
            w_next_state = RUN;
            w_next_rem   = '0;
         end
      end else begin
         case (r_state)
            RUN: begin
               if (w_load_use) begin
                  pc_enable_o   = 1'b0;
                  ifid_enable_o = 1'b0;
                  idex_flush_o  = 1'b1;
                  w_stall_inc   = 1'b1;
                  if (STALL_CYCLES > 1) begin
                     w_next_state = STALL;
                     w_next_rem   = STALL_REM;
                  end
               end
            end
            STALL: begin
               pc_enable_o   = 1'b0;
               ifid_enable_o = 1'b0;
               idex_flush_o  = 1'b1;
               w_stall_inc   = 1'b1;
               w_next_rem    = r_rem - 1'b1;
               if (r_rem == REM_LAST)
                  w_next_state = RUN;
            end
            FLUSH: begin
               // ID holds a wrong-path instruction, so load_use is not looked at.
               ifid_flush_o  = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
               w_next_rem    = r_rem - 1'b1;
               if (r_rem == REM_LAST)
                  w_next_state = RUN;
            end
            default: begin
               w_next_state = RUN;
               w_next_rem   = '0;
            end
         endcase
      end

      // Reset forces the safe output pattern immediately, independent of state.
      if (!reset) begin
         pc_enable_o   = 1'b0;
         ifid_enable_o = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         exmem_flush_o = 1'b1;
         pc_sel_o      = PC_SEL_PC4;
         w_stall_inc   = 1'b0;
         w_flush_inc   = 1'b0;
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_stall_inc),
      .o_count (stall_count_o)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_flush_inc),
      .o_count (flush_count_o)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [4:0]    ifid_rs_i, ifid_rt_i, idex_rt_i;
   logic          idex_mem_read_i, exmem_branch_i, exmem_zero_i, exmem_jmp_i, exmem_topc_i;
   logic          pc_enable_o, ifid_enable_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
   logic [1:0]    pc_sel_o;
   logic [CW-1:0] stall_count_o, flush_count_o;

   pipeline_hazard_controller #(
      .STALL_CYCLES (2),
      .FLUSH_CYCLES (2),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ifid_rs_i       (ifid_rs_i),
      .ifid_rt_i       (ifid_rt_i),
      .idex_mem_read_i (idex_mem_read_i),
      .idex_rt_i       (idex_rt_i),
      .exmem_branch_i  (exmem_branch_i),
      .exmem_zero_i    (exmem_zero_i),
      .exmem_jmp_i     (exmem_jmp_i),
      .exmem_topc_i    (exmem_topc_i),
      .pc_enable_o     (pc_enable_o),
      .ifid_enable_o   (ifid_enable_o),
      .ifid_flush_o    (ifid_flush_o),
      .idex_flush_o    (idex_flush_o),
      .exmem_flush_o   (exmem_flush_o),
      .pc_sel_o        (pc_sel_o),
      .stall_count_o   (stall_count_o),
      .flush_count_o   (flush_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}
   localparam logic [4:0] C_RUN = 5'b11000;
   localparam logic [4:0] C_STL = 5'b00010;
   localparam logic [4:0] C_FLS = 5'b11111;
   localparam logic [4:0] C_RST = 5'b00111;

   typedef struct {
      string         nm;
      logic [4:0]    ctl;
      logic [1:0]    sel;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Drive one cycle of inputs just after the rising edge and queue the
   // response expected for that cycle.
   task automatic step(input string nm, input logic rst_v,
                       input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic z,
                       input logic j, input logic t,
                       input logic [4:0] ctl, input logic [1:0] sel,
                       input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      reset           = rst_v;
      idex_mem_read_i = mr;
      idex_rt_i       = xrt;
      ifid_rs_i       = rs;
      ifid_rt_i       = rt;
      exmem_branch_i  = br;
      exmem_zero_i    = z;
      exmem_jmp_i     = j;
      exmem_topc_i    = t;
      e.nm  = nm;
      e.ctl = ctl;
      e.sel = sel;
      e.sc  = CW'(sc);
      e.fc  = CW'(fc);
      exp_q.push_back(e);
   endtask

   // Monitor: every falling edge, check the response of the cycle in flight.
   initial begin
      exp_t e;
      logic [4:0] act_ctl;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_ctl = {pc_enable_o, ifid_enable_o, ifid_flush_o, idex_flush_o, exmem_flush_o};
            total++;
            if (act_ctl !== e.ctl || pc_sel_o !== e.sel ||
                stall_count_o !== e.sc || flush_count_o !== e.fc) begin
               bad++;
               $display("FAIL %s: got ctl=%b sel=%0d sc=%0d fc=%0d, want ctl=%b sel=%0d sc=%0d fc=%0d",
                        e.nm, act_ctl, pc_sel_o, stall_count_o, flush_count_o,
                        e.ctl, e.sel, e.sc, e.fc);
            end
         end
      end
   end

   initial begin
      int es;
      reset = 1'b0;
      idex_mem_read_i = 1'b0; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
      exmem_branch_i = 1'b0; exmem_zero_i = 1'b0; exmem_jmp_i = 1'b0; exmem_topc_i = 1'b0;

      //     name                rst mr xrt rs rt br z j t  ctl    sel sc fc
      step("reset_hold",        0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
      step("idle",              1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
      step("load_rs",           1, 1, 8, 8, 0, 0, 0, 0, 0, C_STL, 0, 0, 0);
      step("stall_2nd",         1, 0, 0, 0, 0, 0, 0, 0, 0, C_STL, 0, 1, 0);
      step("after_stall",       1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 0);
      step("rt_zero",           1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 0);
      step("no_match",          1, 1, 5, 6, 7, 0, 0, 0, 0, C_RUN, 0, 2, 0);
      step("no_load",           1, 0, 8, 8, 0, 0, 0, 0, 0, C_RUN, 0, 2, 0);
      step("beq_taken",         1, 0, 0, 0, 0, 1, 1, 0, 0, C_FLS, 1, 2, 0);
      step("flush_beq",         1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLS, 0, 2, 1);
      step("beq_not_taken",     1, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN, 0, 2, 1);
      step("jr_and_j",          1, 0, 0, 0, 0, 0, 0, 1, 1, C_FLS, 3, 2, 1);
      step("flush_jr",          1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLS, 0, 2, 2);
      step("jmp",               1, 0, 0, 0, 0, 0, 0, 1, 0, C_FLS, 2, 2, 2);
      step("redir_in_flush",    1, 0, 0, 0, 0, 1, 1, 0, 0, C_FLS, 1, 2, 3);
      step("flush_restarted",   1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLS, 0, 2, 4);
      step("idle2",             1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 4);
      step("lu_and_jmp",        1, 1, 8, 8, 0, 0, 0, 1, 0, C_FLS, 2, 2, 4);
      step("lu_in_flush",       1, 1, 8, 8, 0, 0, 0, 0, 0, C_FLS, 0, 2, 5);
      step("idle3",             1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 5);
      step("load_rt",           1, 1, 9, 0, 9, 0, 0, 0, 0, C_STL, 0, 2, 5);
      step("jr_in_stall",       1, 0, 0, 0, 0, 0, 0, 0, 1, C_FLS, 3, 3, 5);
      step("flush_from_stall",  1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLS, 0, 3, 6);
      step("idle4",             1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 3, 6);

      // Back-to-back load-use hazards drive the 4-bit stall count into saturation.
      for (int k = 0; k < 14; k++) begin
         es = 3 + k;
         if (es > 15) es = 15;
         if (k % 2 == 1)
            step("sat_stall",   1, 0, 0, 0, 0, 0, 0, 0, 0, C_STL, 0, es, 6);
         else if (k % 4 == 0)
            step("sat_load_rs", 1, 1, 10, 10, 3, 0, 0, 0, 0, C_STL, 0, es, 6);
         else
            step("sat_load_rt", 1, 1, 10, 3, 10, 0, 0, 0, 0, C_STL, 0, es, 6);
      end
      step("sat_hold",          1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 15, 6);

      step("beq_before_rst",    1, 0, 0, 0, 0, 1, 1, 0, 0, C_FLS, 1, 15, 6);
      step("rst_mid_flush",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
      step("rst_hold_redir",    0, 0, 0, 0, 0, 1, 1, 0, 0, C_RST, 0, 0, 0);
      step("post_rst_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
      step("post_rst_load",     1, 1, 8, 8, 0, 0, 0, 0, 0, C_STL, 0, 0, 0);
      step("post_rst_stall",    1, 0, 0, 0, 0, 0, 0, 0, 0, C_STL, 0, 1, 0);
      step("post_rst_idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 0);

      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
